// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared types and helpers for the GPIO debounce/interrupt controller
// Contents:
//   int_mode_e    per-pin interrupt mode encoding (2 bits per pin on int_mode)
//   arm_cnt_width width of the post-reset arming counter for a given sync depth
package gpio_pkg;

  typedef enum logic [1:0] {
    INT_LEVEL = 2'b00,
    INT_RISE  = 2'b01,
    INT_FALL  = 2'b10,
    INT_BOTH  = 2'b11
  } int_mode_e;

  // The arming counter runs 0 .. sync_stages+2, so it needs room for sync_stages+3 values.
  function automatic int arm_cnt_width(input int sync_stages);
    return $clog2(sync_stages + 3);
  endfunction

endpackage

// File: rtl/gpio_debounce_cell.sv
// rtl/gpio_debounce_cell.sv - one pin's debounce counter and filtered-value flop
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   tick      shared sample tick from the top-level prescaler
//   load      force filt_out to follow sync_in directly (used while arming)
//   thresh    stable ticks required to accept a change; 0 bypasses the filter
//   sync_in   synchronised pad value
//   filt_out  filtered pin value
module gpio_debounce_cell
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      load,
  input  logic [DEBOUNCE_WIDTH-1:0] thresh,
  input  logic                      sync_in,
  output logic                      filt_out
);

  localparam logic [DEBOUNCE_WIDTH-1:0] ONE = DEBOUNCE_WIDTH'(1);

  logic [DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;
  logic                      filt_q, filt_d;

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (load || (thresh == '0)) begin
      filt_d = sync_in;
      cnt_d  = '0;
    end else if (sync_in == filt_q) begin
      cnt_d = '0;
    end else if (tick) begin
      // Accept on the tick that brings the count up to thresh; >= keeps this safe
      // if thresh is lowered below a count already in progress.
      if (cnt_q >= (thresh - ONE)) begin
        filt_d = sync_in;
        cnt_d  = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_out = filt_q;

endmodule

// File: rtl/gpio_debounce_irq_ctrl.sv
// rtl/gpio_debounce_irq_ctrl.sv - GPIO pad control, input sync/debounce and interrupt status
// Optional feature macro: GPIO_DEBOUNCE_EN (tick-based per-pin debounce filter).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   gpio_pins        pad pins (bidirectional)
//   gpio_dir/od/out  per-pin output enable, open-drain select, output value
//   gpio_in          filtered input value
//   debounce_thresh  stable ticks needed to accept a change (debounce build only)
//   int_enable       per-pin mask for int_out
//   int_mode         2 bits per pin: level / rise / fall / both
//   int_polarity     level-mode active level
//   int_clear        write-1-to-clear status
//   int_status       sticky unmasked status
//   int_out          OR of enabled status bits
module gpio_debounce_irq_ctrl
  import gpio_pkg::*;
#(
  parameter int PIN_COUNT      = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_WIDTH = 8,
  parameter int PRESCALE_DIV   = 100
) (
  input  logic                      clk,
  input  logic                      rst,
  inout  wire  [PIN_COUNT-1:0]      gpio_pins,
  input  logic [PIN_COUNT-1:0]      gpio_dir,
  input  logic [PIN_COUNT-1:0]      gpio_od,
  input  logic [PIN_COUNT-1:0]      gpio_out,
  output logic [PIN_COUNT-1:0]      gpio_in,
  input  logic [DEBOUNCE_WIDTH-1:0] debounce_thresh,
  input  logic [PIN_COUNT-1:0]      int_enable,
  input  logic [2*PIN_COUNT-1:0]    int_mode,
  input  logic [PIN_COUNT-1:0]      int_polarity,
  input  logic [PIN_COUNT-1:0]      int_clear,
  output logic [PIN_COUNT-1:0]      int_status,
  output logic                      int_out
);

  // gpio_in loads SYNC_STAGES+1 edges after reset and prev one edge later, so the
  // edge detector only sees a stable history once the counter reaches SYNC_STAGES+2.
  localparam int                ARM_W    = arm_cnt_width(SYNC_STAGES);
  localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES + 2);

  // Pad drive
  for (genvar i = 0; i < PIN_COUNT; i++) begin : g_drive
    assign gpio_pins[i] = !gpio_dir[i] ? 1'bz :
                          gpio_od[i]   ? (gpio_out[i] ? 1'bz : 1'b0) :
                                         gpio_out[i];
  end

  // Input synchroniser
  logic [PIN_COUNT-1:0] sync_q [SYNC_STAGES];
  logic [PIN_COUNT-1:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = gpio_pins;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < SYNC_STAGES; s++) begin
      if (rst) sync_q[s] <= '0;
      else     sync_q[s] <= sync_d[s];
    end
  end

  logic [PIN_COUNT-1:0] sync_last;
  assign sync_last = sync_q[SYNC_STAGES-1];

  // Arming counter
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             armed;

  assign armed = (arm_cnt_q == ARM_DONE);

  always_comb begin
    arm_cnt_d = arm_cnt_q;
    if (!armed) arm_cnt_d = arm_cnt_q + ARM_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) arm_cnt_q <= '0;
    else     arm_cnt_q <= arm_cnt_d;
  end

  // Input filter
  logic [PIN_COUNT-1:0] filt;

`ifdef GPIO_DEBOUNCE_EN
  localparam int               PRE_W    = $clog2(PRESCALE_DIV + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;

  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

  // While arming, filters track the synchroniser directly so a pin already
  // active at reset exit settles before edge detection starts.
  for (genvar i = 0; i < PIN_COUNT; i++) begin : g_cell
    gpio_debounce_cell #(
      .DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .load     (!armed),
      .thresh   (debounce_thresh),
      .sync_in  (sync_last[i]),
      .filt_out (filt[i])
    );
  end
`else
  localparam int unused_prescale_div = PRESCALE_DIV;
  logic          unused_thresh;
  assign unused_thresh = ^debounce_thresh;

  logic [PIN_COUNT-1:0] gpio_in_q, gpio_in_d;

  assign gpio_in_d = sync_last;

  always_ff @(posedge clk) begin
    if (rst) gpio_in_q <= '0;
    else     gpio_in_q <= gpio_in_d;
  end

  assign filt = gpio_in_q;
`endif

  assign gpio_in = filt;

  // Edge detection and sticky status
  logic [PIN_COUNT-1:0] prev_q, prev_d;
  logic [PIN_COUNT-1:0] status_q, status_d;
  logic [PIN_COUNT-1:0] edge_set, lvl_set;

  assign prev_d = filt;

  always_comb begin
    edge_set = '0;
    lvl_set  = '0;
    for (int i = 0; i < PIN_COUNT; i++) begin
      case (int_mode_e'(int_mode[2*i +: 2]))
        INT_LEVEL: lvl_set[i]  = (filt[i] == int_polarity[i]);
        INT_RISE:  edge_set[i] = filt[i] & ~prev_q[i];
        INT_FALL:  edge_set[i] = ~filt[i] & prev_q[i];
        default:   edge_set[i] = filt[i] ^ prev_q[i];
      endcase
    end
    // An edge landing with a clear survives so no event is lost; a level set
    // yields to the clear for one cycle and re-asserts while the level persists.
    status_d = (status_q & ~int_clear)
             | ({PIN_COUNT{armed}} & edge_set)
             | ({PIN_COUNT{armed}} & lvl_set & ~int_clear);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= '0;
      status_q <= '0;
    end else begin
      prev_q   <= prev_d;
      status_q <= status_d;
    end
  end

  assign int_status = status_q;
  assign int_out    = |(status_q & int_enable);

endmodule

// File: tb/tb_gpio_debounce_irq_ctrl.sv
// tb/tb_gpio_debounce_irq_ctrl.sv - directed self-checking bench for gpio_debounce_irq_ctrl
module tb_gpio_debounce_irq_ctrl;

  localparam int N = 32;

  logic              clk = 1'b0;
  logic              rst;
  wire  [N-1:0]      gpio_pins;
  logic [N-1:0]      gpio_dir, gpio_od, gpio_out;
  logic [N-1:0]      gpio_in;
  logic [7:0]        debounce_thresh;
  logic [N-1:0]      int_enable, int_polarity, int_clear;
  logic [2*N-1:0]    int_mode;
  logic [N-1:0]      int_status;
  logic              int_out;

  logic [N-1:0]      ext_en, ext_val;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;
  logic bad;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_pad
    assign gpio_pins[i] = ext_en[i] ? ext_val[i] : 1'bz;
    pullup pu (gpio_pins[i]);
  end

  gpio_debounce_irq_ctrl #(
    .PIN_COUNT      (N),
    .SYNC_STAGES    (2),
    .DEBOUNCE_WIDTH (8),
    .PRESCALE_DIV   (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .gpio_pins       (gpio_pins),
    .gpio_dir        (gpio_dir),
    .gpio_od         (gpio_od),
    .gpio_out        (gpio_out),
    .gpio_in         (gpio_in),
    .debounce_thresh (debounce_thresh),
    .int_enable      (int_enable),
    .int_mode        (int_mode),
    .int_polarity    (int_polarity),
    .int_clear       (int_clear),
    .int_status      (int_status),
    .int_out         (int_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    gpio_dir        = '0;
    gpio_od         = '0;
    gpio_out        = '0;
    int_enable      = '1;
    int_polarity    = '0;
    int_clear       = '0;
    int_mode        = {N{2'b01}};
    debounce_thresh = 8'd3;
    ext_en          = ~32'h0000_0002;
    ext_val         = '1;

    repeat (3) step();
    check("reset_status",  int_status, 0);
    check("reset_int_out", int_out,    0);
    check("reset_gpio_in", gpio_in,    0);

    // Pins already high at reset exit must not raise a rise event.
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("arm_no_spurious", int_status, 0);
    end
    check("gpio_in_after_reset", gpio_in, 32'hFFFF_FFFF);

    // Pad drive on pin 1 (bench leaves it undriven, pullup present)
    gpio_dir[1] = 1'b1; gpio_od[1] = 1'b1; gpio_out[1] = 1'b0;
    #1 check("od_drive_low", gpio_pins[1], 0);
    gpio_out[1] = 1'b1;
    #1 check("od_release_pullup", gpio_pins[1], 1);
    gpio_od[1] = 1'b0; gpio_out[1] = 1'b0;
    #1 check("pp_drive_low", gpio_pins[1], 0);
    gpio_dir[1] = 1'b0;
    #1 check("input_hiz_pullup", gpio_pins[1], 1);
    repeat (6) step();
    int_clear = '1;
    step();
    int_clear = '0;
    check("clear_all", int_status, 0);

    // Pin 0 rise, mode rise, no debounce: status exactly 4 clocks later
    int_enable = '0;
    ext_val[0] = 1'b0;
    repeat (6) step();
    check("fall_ignored_in_rise_mode", int_status, 0);
    ext_val[0] = 1'b1;
    repeat (3) step();
    check("rise_not_yet_at_3", int_status[0], 0);
    step();
    check("rise_set_at_4", int_status[0], 1);
    check("int_out_masked", int_out, 0);
    int_enable[0] = 1'b1;
    #1 check("int_out_enabled", int_out, 1);
    int_clear[0] = 1'b1;
    step();
    int_clear[0] = 1'b0;
    check("rise_cleared", int_status[0], 0);
    check("int_out_after_clear", int_out, 0);

    // Pin 3, both-edge mode
    ext_val[3] = 1'b0;
    repeat (6) step();
    int_mode[7:6] = 2'b11;
    step();
    ext_val[3] = 1'b1;
    repeat (4) step();
    check("both_rise_set", int_status[3], 1);
    int_clear[3] = 1'b1;
    step();
    int_clear[3] = 1'b0;
    check("both_cleared", int_status[3], 0);
    ext_val[3] = 1'b0;
    repeat (4) step();
    check("both_fall_set", int_status[3], 1);
    ext_val[3] = 1'b1;
    repeat (3) step();
    int_clear[3] = 1'b1;
    step();
    int_clear[3] = 1'b0;
    check("edge_wins_over_clear", int_status[3], 1);
    step();
    check("edge_wins_hold", int_status[3], 1);

    // Pin 5, level-low mode
    int_mode[11:10] = 2'b00;
    int_polarity[5] = 1'b0;
    step();
    check("level_no_match", int_status[5], 0);
    ext_val[5] = 1'b0;
    repeat (5) step();
    check("level_low_set", int_status[5], 1);
    int_clear[5] = 1'b1;
    step();
    int_clear[5] = 1'b0;
    check("level_clear_drop", int_status[5], 0);
    step();
    check("level_reassert", int_status[5], 1);
    int_mode[11:10] = 2'b01;
    step();
    check("mode_change_keeps_status", int_status[5], 1);

    // Reset in the middle of an event
    ext_val[0] = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("midreset_status",  int_status, 0);
    check("midreset_gpio_in", gpio_in,    0);
    check("midreset_int_out", int_out,    0);
    rst = 1'b0;

`ifdef GPIO_DEBOUNCE_EN
    debounce_thresh = 8'd3;
    repeat (10) step();
    check("db_settled", gpio_in[6], 1);

    // 8-clock glitch sees at most two ticks: rejected
    ext_val[6] = 1'b0;
    repeat (8) step();
    ext_val[6] = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      step();
      if (gpio_in[6] !== 1'b1) bad = 1'b1;
    end
    check("db_glitch_rejected", bad, 0);

    // Held change: 2 sync edges, then third tick lands 9..12 edges later
    ext_val[6] = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      step();
      if (gpio_in[6] == 1'b0) lat = k;
    end
    check("db_held_latency_window", (lat >= 11 && lat <= 14), 1);

    // thresh=0 bypasses the filter
    debounce_thresh = 8'd0;
    ext_val[6] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      step();
      if (gpio_in[6] == 1'b1) lat = k;
    end
    check("db_bypass_latency", lat, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
